bcd_scan_counter: RTL and testbench

Four-digit BCD up/down counter with a built-in display scanner. It sits directly upstream of the BCD-to-7-segment decoder. Each cycle it presents one BCD digit on `digit[3:0]`, which drives the decoder's 4-bit input (bit 0 = LSB), together with a one-hot digit-enable `an[3:0]`. One shared decoder can therefore drive a multiplexed 4-digit display. The full count is also exported on `bcd[15:0]` for other consumers.

---
 rtl/bcd_scan_counter_if.sv | 40 ++++
 rtl/bcd_scan_counter.sv | 158 +++++++++++++++
 tb/tb_bcd_scan_counter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/bcd_scan_counter_if.sv
// Control and display bundle for bcd_scan_counter.
// master drives count controls; slave is the counter.
interface bcd_scan_counter_if;
  logic        clr;
  logic        load;
  logic [15:0] load_val;
  logic        en;
  logic        up_dn;
  logic        lz_blank;
  logic [15:0] bcd;
  logic        carry;
  logic [3:0]  digit;
  logic [3:0]  an;

  modport master (
    output clr,
    output load,
    output load_val,
    output en,
    output up_dn,
    output lz_blank,
    input  bcd,
    input  carry,
    input  digit,
    input  an
  );

  modport slave (
    input  clr,
    input  load,
    input  load_val,
    input  en,
    input  up_dn,
    input  lz_blank,
    output bcd,
    output carry,
    output digit,
    output an
  );
endinterface

// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up/down counter with a
// multiplexed display scanner.
module bcd_scan_counter #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_scan_counter_if.slave  bus
);

  localparam logic [15:0] DIV_MAX =
    16'(SCAN_DIV - 1);

  logic [15:0] bcd_q;
  logic [15:0] bcd_d;
  logic        carry_q;
  logic        carry_d;
  logic [15:0] div_q;
  logic [15:0] div_d;
  logic [1:0]  scan_idx_q;
  logic [1:0]  scan_idx_d;

  logic [16:0] inc_r;
  logic [16:0] dec_r;
  logic [15:0] sat_val;
  logic [3:0]  blank;
  logic [3:0]  an_raw;

  // Result bit 16 is the wrap flag.
  function automatic logic [16:0] bcd_inc(
    input logic [15:0] v
  );
    logic [15:0] r;
    logic        c;
    logic [3:0]  n;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = v[i*4 +: 4];
      if (c) begin
        if (n >= 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = n + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  function automatic logic [16:0] bcd_dec(
    input logic [15:0] v
  );
    logic [15:0] r;
    logic        b;
    logic [3:0]  n;
    r = v;
    b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = v[i*4 +: 4];
      if (b) begin
        if (n == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
        end else begin
          r[i*4 +: 4] = n - 4'd1;
          b = 1'b0;
        end
      end
    end
    return {b, r};
  endfunction

  function automatic logic [15:0] bcd_sat(
    input logic [15:0] v
  );
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      if (v[i*4 +: 4] > 4'd9) begin
        r[i*4 +: 4] = 4'd9;
      end else begin
        r[i*4 +: 4] = v[i*4 +: 4];
      end
    end
    return r;
  endfunction

  assign inc_r   = bcd_inc(bcd_q);
  assign dec_r   = bcd_dec(bcd_q);
  assign sat_val = bcd_sat(bus.load_val);

  always_comb begin
    bcd_d   = bcd_q;
    carry_d = 1'b0;
    if (bus.clr) begin
      bcd_d = 16'h0000;
    end else if (bus.load) begin
      bcd_d = sat_val;
    end else if (bus.en) begin
      if (bus.up_dn) begin
        bcd_d   = inc_r[15:0];
        carry_d = inc_r[16];
      end else begin
        bcd_d   = dec_r[15:0];
        carry_d = dec_r[16];
      end
    end
  end

  // Scanner runs freely, unaffected by count controls.
  always_comb begin
    div_d      = div_q + 16'd1;
    scan_idx_d = scan_idx_q;
    if (div_q >= DIV_MAX) begin
      div_d      = 16'd0;
      scan_idx_d = scan_idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q      <= 16'h0000;
      carry_q    <= 1'b0;
      div_q      <= 16'd0;
      scan_idx_q <= 2'd0;
    end else begin
      bcd_q      <= bcd_d;
      carry_q    <= carry_d;
      div_q      <= div_d;
      scan_idx_q <= scan_idx_d;
    end
  end

  always_comb begin
    blank    = 4'b0000;
    blank[3] = (bcd_q[15:12] == 4'd0);
    blank[2] = blank[3] && (bcd_q[11:8] == 4'd0);
    blank[1] = blank[2] && (bcd_q[7:4] == 4'd0);
  end

  always_comb begin
    an_raw = 4'b0001;
    unique case (scan_idx_q)
      2'd0: an_raw = 4'b0001;
      2'd1: an_raw = 4'b0010;
      2'd2: an_raw = 4'b0100;
      2'd3: an_raw = 4'b1000;
    endcase
  end

  assign bus.bcd   = bcd_q;
  assign bus.carry = carry_q;
  assign bus.digit = bcd_q[{scan_idx_q, 2'b00} +: 4];
  assign bus.an    =
    (bus.lz_blank && blank[scan_idx_q]) ?
    4'b0000 : an_raw;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Scoreboard bench for bcd_scan_counter against a
// decimal-arithmetic reference model.
module tb_bcd_scan_counter;

  localparam int D = 4;

  typedef struct {
    logic [15:0] bcd;
    logic        carry;
    logic [3:0]  digit;
    logic [3:0]  an;
  } exp_t;

  logic clk;
  logic rst_n;
  bcd_scan_counter_if bus ();

  bcd_scan_counter #(.SCAN_DIV(D)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  int   cnt;
  int   k;
  int   p10 [4] = '{1, 10, 100, 1000};

  function automatic logic [15:0] to_bcd(int c);
    logic [15:0] r;
    for (int i = 0; i < 4; i++)
      r[i*4 +: 4] = 4'((c / p10[i]) % 10);
    return r;
  endfunction

  function automatic int sat_dec(logic [15:0] v);
    int s;
    int n;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      n = int'(v[i*4 +: 4]);
      if (n > 9) n = 9;
      s += n * p10[i];
    end
    return s;
  endfunction

  task automatic chk(string nm, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, req, $time);
    end
  endtask

  // Drive one cycle of stimulus and predict the
  // visible state after the following edge.
  task automatic step(bit c, bit l, logic [15:0] lv,
                      bit e, bit u, bit lz);
    exp_t x;
    int   idx;
    @(negedge clk);
    rst_n        = 1'b1;
    bus.clr      = c;
    bus.load     = l;
    bus.load_val = lv;
    bus.en       = e;
    bus.up_dn    = u;
    bus.lz_blank = lz;
    x.carry = 1'b0;
    if (c) cnt = 0;
    else if (l) cnt = sat_dec(lv);
    else if (e && u) begin
      x.carry = (cnt == 9999);
      cnt = (cnt + 1) % 10000;
    end else if (e) begin
      x.carry = (cnt == 0);
      cnt = (cnt + 9999) % 10000;
    end
    k++;
    idx = (k / D) % 4;
    x.bcd   = to_bcd(cnt);
    x.digit = 4'((cnt / p10[idx]) % 10);
    x.an    = 4'(1 << idx);
    if (lz && idx > 0 && cnt < p10[idx]) x.an = 4'b0000;
    q.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("bcd", int'(bus.bcd), int'(x.bcd));
        chk("carry", int'(bus.carry), int'(x.carry));
        chk("digit", int'(bus.digit), int'(x.digit));
        chk("an", int'(bus.an), int'(x.an));
      end
    end
  end

  task automatic reset_checks(string tag);
    chk({tag, "_bcd"}, int'(bus.bcd), 0);
    chk({tag, "_carry"}, int'(bus.carry), 0);
    chk({tag, "_an"}, int'(bus.an), 1);
    chk({tag, "_digit"}, int'(bus.digit), 0);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    reset_checks("async_rst");
    cnt = 0;
    k   = 0;
    @(posedge clk);
    #1;
    reset_checks("held_rst");
  endtask

  initial begin : driver
    int wait_cyc;
    rst_n        = 1'b0;
    bus.clr      = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = 16'h0000;
    bus.en       = 1'b0;
    bus.up_dn    = 1'b1;
    bus.lz_blank = 1'b0;
    cnt = 0;
    k   = 0;
    #3;
    reset_checks("por");
    @(posedge clk);
    @(posedge clk);

    repeat (20) step(0, 0, 16'h0, 0, 1, 0);

    step(0, 1, 16'h9998, 0, 1, 0);
    repeat (3) step(0, 0, 16'h0, 1, 1, 0);

    step(0, 1, 16'h1000, 0, 0, 0);
    repeat (2) step(0, 0, 16'h0, 1, 0, 0);
    step(0, 1, 16'h0000, 0, 0, 0);
    step(0, 0, 16'h0, 1, 0, 0);

    step(0, 1, 16'hFA3C, 0, 1, 0);
    step(0, 1, 16'hFA3C, 1, 1, 0);
    step(1, 1, 16'h5555, 1, 1, 0);

    step(0, 1, 16'h0042, 0, 1, 1);
    repeat (20) step(0, 0, 16'h0, 0, 1, 1);
    repeat (16) step(0, 0, 16'h0, 0, 1, 0);

    step(0, 1, 16'h1234, 0, 1, 0);
    repeat (5) step(0, 0, 16'h0, 0, 1, 0);
    async_reset();
    repeat (8) step(0, 0, 16'h0, 0, 1, 1);

    for (int i = 0; i < 1500; i++) begin
      logic [15:0] lv;
      bit c, l;
      c  = ($urandom_range(0, 49) == 0);
      l  = ($urandom_range(0, 19) == 0);
      lv = 16'($urandom);
      case ($urandom_range(0, 3))
        0: lv = 16'h9997;
        1: lv = 16'h0002;
        2: lv = {4'h0, 4'h0, lv[7:0]};
        default: ;
      endcase
      step(c, l, lv, ($urandom_range(0, 3) != 0),
           1'($urandom), 1'($urandom));
      if (i == 700) async_reset();
    end

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    chk("drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
